peripheral_ahb3_arbiter: RTL and testbench
==========================================

# peripheral_ahb3_arbiter

Round-robin AHB3-Lite slave-port arbiter that lets MASTERS independent AHB-Lite requesters share one downstream AHB-Lite slave, normally the AHB-to-APB bridge of the GPIO peripheral. Each requester's address/control and write data are captured locally, the requester is held off with HREADYOUT low, and granted transfers are replayed one at a time on the downstream port. The block is single-clock (HCLK) and sits directly in front of the bridge's AHB slave interface.

## Interface
- MASTERS, 4, number of upstream requesters (2..8)
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width

Ports:
- HRESETn  in  1  reset, asynchronous, active-low; clock HCLK
- HCLK  in  1  clock
- HSEL/HWRITE/HMASTLOCK/HREADY  in  [MASTERS-1:0]  per-requester AHB control
- HADDR  in  [MASTERS-1:0][HADDR_SIZE-1:0]  per-requester address
- HWDATA  in  [MASTERS-1:0][HDATA_SIZE-1:0]  per-requester write data
- HSIZE  in  [MASTERS-1:0][2:0]; HPROT  in  [MASTERS-1:0][3:0]; HTRANS  in  [MASTERS-1:0][1:0]
- HRDATA  out  [MASTERS-1:0][HDATA_SIZE-1:0]  per-requester read data
- HREADYOUT/HRESP  out  [MASTERS-1:0]  per-requester response
- M_HSEL/M_HWRITE/M_HMASTLOCK/M_HREADY  out  1  downstream control
- M_HADDR  out  HADDR_SIZE; M_HWDATA  out  HDATA_SIZE; M_HSIZE  out  3; M_HPROT  out  4; M_HTRANS  out  2
- M_HRDATA  in  HDATA_SIZE; M_HREADYOUT  in  1; M_HRESP  in  1

## Operation
- Capture: HSEL[i] & HREADY[i] & HTRANS[i] in {NONSEQ, SEQ} sets pend[i], stores addr/write/size/prot/lock; next cycle HREADYOUT[i]=0 and HWDATA[i] is latched. IDLE/BUSY or unselected: HREADYOUT[i]=1, HRESP[i]=OKAY (zero-wait).
- HBURST is ignored; every beat is an independent downstream NONSEQ.
- FSM: ARB_IDLE -> ARB_ADDR -> ARB_DATA -> ARB_IDLE.
  - ARB_IDLE: if any pend (with write data latched), grant g = first pending at or after last+1 (round-robin, wrap MASTERS-1 -> 0); go ARB_ADDR.
  - ARB_ADDR: M_HSEL=1, M_HTRANS=NONSEQ, M_HREADY=1, address/control of g; go ARB_DATA.
  - ARB_DATA: M_HWDATA=wdata[g], M_HTRANS=IDLE, M_HSEL=0, M_HREADY=M_HREADYOUT. Each cycle register HRESP[g]<=M_HRESP, HREADYOUT[g]<=M_HREADYOUT, HRDATA[g]<=M_HRDATA. On M_HREADYOUT=1: clear pend[g], last<=g, go ARB_IDLE.
- Error: downstream two-cycle ERROR maps to requester two-cycle ERROR (0/1 then 1/1) one cycle later.
- Simultaneous completion and new capture on same requester: capture wins, pend[i] stays set.
- Reset mid-transfer: all pend cleared, FSM to ARB_IDLE, last=MASTERS-1.

## Timing
- Reset: HREADYOUT all 1, HRESP all OKAY, HRDATA 0, M_HSEL 0, M_HTRANS IDLE, M_HREADY 1, M_HMASTLOCK 0, M_HADDR/M_HWDATA/M_HSIZE/M_HPROT/M_HWRITE 0.
- Uncontended, downstream zero-wait: requester address phase cycle 0, downstream address cycle 2, data cycle 3, requester HREADYOUT=1 cycle 4.
- Each additional downstream wait state adds one cycle; each queued requester ahead adds its full transfer.
- Outputs registered; no combinational path requester-to-downstream.

## Configuration
- PERIPHERAL_AHB3_ARB_LOCK_EN defined: captured HMASTLOCK forwarded on M_HMASTLOCK; while last granted transfer had lock=1, ARB_IDLE grants only that requester and waits for it, until it completes a transfer with lock=0.
- Undefined: HMASTLOCK ignored, M_HMASTLOCK tied 0, pure round-robin.

## Structure
- peripheral_ahb3_pkg: arbiter FSM state typedef (ARB_IDLE/ARB_ADDR/ARB_DATA); existing HTRANS/HRESP constants reused.
- Sub-module peripheral_ahb3_rr_arbiter: combinational round-robin picker (pend vector, last pointer -> one-hot grant, index, valid).

## Test plan
- Single requester 0 write 0x0000_0010 data 0xA5, downstream zero-wait -> M_HADDR=0x10, M_HWDATA=0xA5, HREADYOUT[0] high in cycle 4, HRESP OKAY.
- Requesters 0..3 capture in the same cycle -> downstream order 0,1,2,3; next simultaneous round starts at 0 after last=3.
- Read, downstream 3 wait states, M_HRDATA=0x5A -> HRDATA[1]=0x5A with HREADYOUT[1]=1 in cycle 7.
- Downstream ERROR on requester 2 -> HREADYOUT[2]/HRESP[2] = 0/1 then 1/1; pend[2] cleared; other requesters unaffected.
- HRESETn asserted in ARB_DATA -> all outputs at reset values same cycle; post-reset request served normally.
- With LOCK_EN: requester 1 locked transfer while requester 0 pending -> requester 1's next transfer granted before requester 0; without macro -> requester 0 granted first.

Source files
------------

// File: rtl/peripheral_ahb3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_ahb3_pkg
// Description : Shared AHB3-Lite encodings and the slave-port arbiter
//               FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_ahb3_pkg;

  // Arbiter FSM state encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_ADDR = 2'd1;
  localparam arb_state_t ARB_DATA = 2'd2;

  // AHB transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB response
  localparam logic HRESP_OKAY = 1'b0;

endpackage
`default_nettype wire

// File: rtl/peripheral_ahb3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_ahb3_rr_arbiter
// Description : Combinational round-robin picker. Selects the first pending
//               requester at or after last+1, wrapping MASTERS-1 -> 0.
//               The last owner itself is considered last of all.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_ahb3_rr_arbiter #(
  parameter int MASTERS = 4,
  parameter int IW      = 2
) (
  input  logic [MASTERS-1:0] pend,
  input  logic [IW-1:0]      last,
  output logic [MASTERS-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  localparam logic [IW:0] M_W = (IW+1)'(MASTERS);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk from the farthest candidate down to the nearest so the nearest
  // pending requester after 'last' is the one that sticks.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = |pend;
    sum   = '0;
    cand  = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      sum = {1'b0, last} + (IW+1)'(k);
      if (sum >= M_W) sum = sum - M_W;
      cand = sum[IW-1:0];
      if (pend[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/peripheral_ahb3_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_ahb3_arbiter
// Description : Round-robin AHB3-Lite slave-port arbiter. Captures each
//               requester's transfer, stalls it with HREADYOUT low and
//               replays granted transfers one at a time downstream.
//               Optional macro PERIPHERAL_AHB3_ARB_LOCK_EN forwards
//               HMASTLOCK and keeps the grant with a locked requester.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_ahb3_arbiter
  import peripheral_ahb3_pkg::*;
#(
  parameter int MASTERS    = 4,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                                  HRESETn,
  input  logic                                  HCLK,
  input  logic [MASTERS-1:0]                    HSEL,
  input  logic [MASTERS-1:0]                    HWRITE,
  input  logic [MASTERS-1:0]                    HMASTLOCK,
  input  logic [MASTERS-1:0]                    HREADY,
  input  logic [MASTERS-1:0][HADDR_SIZE-1:0]    HADDR,
  input  logic [MASTERS-1:0][HDATA_SIZE-1:0]    HWDATA,
  input  logic [MASTERS-1:0][2:0]               HSIZE,
  input  logic [MASTERS-1:0][3:0]               HPROT,
  input  logic [MASTERS-1:0][1:0]               HTRANS,
  output logic [MASTERS-1:0][HDATA_SIZE-1:0]    HRDATA,
  output logic [MASTERS-1:0]                    HREADYOUT,
  output logic [MASTERS-1:0]                    HRESP,
  output logic                                  M_HSEL,
  output logic                                  M_HWRITE,
  output logic                                  M_HMASTLOCK,
  output logic                                  M_HREADY,
  output logic [HADDR_SIZE-1:0]                 M_HADDR,
  output logic [HDATA_SIZE-1:0]                 M_HWDATA,
  output logic [2:0]                            M_HSIZE,
  output logic [3:0]                            M_HPROT,
  output logic [1:0]                            M_HTRANS,
  input  logic [HDATA_SIZE-1:0]                 M_HRDATA,
  input  logic                                  M_HREADYOUT,
  input  logic                                  M_HRESP
);

  localparam int             IW       = $clog2(MASTERS);
  localparam logic [IW-1:0]  LAST_RST = IW'(MASTERS - 1);

  logic [MASTERS-1:0]                 capture;
  logic [MASTERS-1:0]                 data_phase;
  logic [MASTERS-1:0]                 pend;
  logic [MASTERS-1:0]                 eligible;
  logic [MASTERS-1:0][HADDR_SIZE-1:0] req_addr;
  logic [MASTERS-1:0][HDATA_SIZE-1:0] req_wdata;
  logic [MASTERS-1:0]                 req_write;
  logic [MASTERS-1:0][2:0]            req_size;
  logic [MASTERS-1:0][3:0]            req_prot;

  arb_state_t                         state;
  logic [IW-1:0]                      last;
  logic [IW-1:0]                      grant_idx;
  logic [MASTERS-1:0]                 rr_onehot_unused;
  logic [IW-1:0]                      rr_idx;
  logic                               rr_valid;

  // A requester address phase is taken when selected, ready and active.
  always_comb begin
    capture = '0;
    for (int i = 0; i < MASTERS; i++)
      capture[i] = HSEL[i] & HREADY[i] &
                   ((HTRANS[i] == HTRANS_NONSEQ) | (HTRANS[i] == HTRANS_SEQ));
  end

  // Hold each requester's address/control; write data follows one cycle later,
  // which is still a cycle before the downstream data phase needs it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_phase <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= '0;
      req_size   <= '0;
      req_prot   <= '0;
    end else begin
      data_phase <= capture;
      for (int i = 0; i < MASTERS; i++) begin
        if (capture[i]) begin
          req_addr[i]  <= HADDR[i];
          req_write[i] <= HWRITE[i];
          req_size[i]  <= HSIZE[i];
          req_prot[i]  <= HPROT[i];
        end
        if (data_phase[i]) req_wdata[i] <= HWDATA[i];
      end
    end
  end

`ifdef PERIPHERAL_AHB3_ARB_LOCK_EN
  logic [MASTERS-1:0] req_lock;
  logic               locked;

  // Track per-requester lock, forward it downstream and remember whether the
  // last completed transfer was locked.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_lock    <= '0;
      locked      <= 1'b0;
      M_HMASTLOCK <= 1'b0;
    end else begin
      for (int i = 0; i < MASTERS; i++)
        if (capture[i]) req_lock[i] <= HMASTLOCK[i];
      if (state == ARB_IDLE && rr_valid) M_HMASTLOCK <= req_lock[rr_idx];
      if (state == ARB_DATA && M_HREADYOUT) locked <= req_lock[grant_idx];
    end
  end

  // While a locked sequence is open only its owner may be granted.
  always_comb begin
    eligible = pend;
    if (locked) begin
      eligible       = '0;
      eligible[last] = pend[last];
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^HMASTLOCK;
  assign M_HMASTLOCK = 1'b0;
  assign eligible    = pend;
`endif

  peripheral_ahb3_rr_arbiter #(
    .MASTERS (MASTERS),
    .IW      (IW)
  ) u_rr (
    .pend  (eligible),
    .last  (last),
    .grant (rr_onehot_unused),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  // The downstream slave's ready is only meaningful during the data phase.
  assign M_HREADY = (state == ARB_DATA) ? M_HREADYOUT : 1'b1;

  // Grant FSM, downstream replay and per-requester response registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ARB_IDLE;
      last      <= LAST_RST;
      grant_idx <= '0;
      pend      <= '0;
      HREADYOUT <= '1;
      HRESP     <= '0;
      HRDATA    <= '0;
      M_HSEL    <= 1'b0;
      M_HTRANS  <= HTRANS_IDLE;
      M_HADDR   <= '0;
      M_HWDATA  <= '0;
      M_HWRITE  <= 1'b0;
      M_HSIZE   <= '0;
      M_HPROT   <= '0;
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (!pend[i]) begin
          HREADYOUT[i] <= 1'b1;
          HRESP[i]     <= HRESP_OKAY;
        end
      end
      case (state)
        ARB_IDLE: begin
          if (rr_valid) begin
            grant_idx <= rr_idx;
            state     <= ARB_ADDR;
            M_HSEL    <= 1'b1;
            M_HTRANS  <= HTRANS_NONSEQ;
            M_HADDR   <= req_addr[rr_idx];
            M_HWRITE  <= req_write[rr_idx];
            M_HSIZE   <= req_size[rr_idx];
            M_HPROT   <= req_prot[rr_idx];
          end
        end
        ARB_ADDR: begin
          state    <= ARB_DATA;
          M_HSEL   <= 1'b0;
          M_HTRANS <= HTRANS_IDLE;
          M_HWDATA <= req_wdata[grant_idx];
        end
        ARB_DATA: begin
          HRESP[grant_idx]     <= M_HRESP;
          HREADYOUT[grant_idx] <= M_HREADYOUT;
          HRDATA[grant_idx]    <= M_HRDATA;
          if (M_HREADYOUT) begin
            pend[grant_idx] <= 1'b0;
            last            <= grant_idx;
            state           <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
      // A new capture overrides completion on the same requester.
      for (int i = 0; i < MASTERS; i++) begin
        if (capture[i]) begin
          pend[i]      <= 1'b1;
          HREADYOUT[i] <= 1'b0;
          HRESP[i]     <= HRESP_OKAY;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_ahb3_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_ahb3_arbiter
// Description : Directed self-checking bench for peripheral_ahb3_arbiter.
//               Honours PERIPHERAL_AHB3_ARB_LOCK_EN for the lock scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_ahb3_arbiter;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [3:0]        HSEL, HWRITE, HMASTLOCK, HREADY;
  logic [3:0][31:0]  HADDR, HWDATA, HRDATA;
  logic [3:0][2:0]   HSIZE;
  logic [3:0][3:0]   HPROT;
  logic [3:0][1:0]   HTRANS;
  logic [3:0]        HREADYOUT, HRESP;
  logic              M_HSEL, M_HWRITE, M_HMASTLOCK, M_HREADY;
  logic [31:0]       M_HADDR, M_HWDATA, M_HRDATA;
  logic [2:0]        M_HSIZE;
  logic [3:0]        M_HPROT;
  logic [1:0]        M_HTRANS;
  logic              M_HREADYOUT, M_HRESP;

  int checks = 0;
  int errors = 0;

  peripheral_ahb3_arbiter #(.MASTERS(4), .HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .HSEL(HSEL), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HPROT(HPROT), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .M_HSEL(M_HSEL), .M_HWRITE(M_HWRITE), .M_HMASTLOCK(M_HMASTLOCK), .M_HREADY(M_HREADY),
    .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA), .M_HSIZE(M_HSIZE), .M_HPROT(M_HPROT),
    .M_HTRANS(M_HTRANS), .M_HRDATA(M_HRDATA), .M_HREADYOUT(M_HREADYOUT), .M_HRESP(M_HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic w, input logic lk);
    HSEL[i] = 1'b1; HTRANS[i] = 2'b10; HADDR[i] = a; HWRITE[i] = w;
    HMASTLOCK[i] = lk; HSIZE[i] = 3'b010; HPROT[i] = 4'b0011;
  endtask

  task automatic idle_req(input int i);
    HSEL[i] = 1'b0; HTRANS[i] = 2'b00; HMASTLOCK[i] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge HCLK);
    #1;
    checks++; if (HREADYOUT !== 4'hF) begin errors++; $display("FAIL rst_hreadyout got=%h exp=f", HREADYOUT); end
    checks++; if (HRESP !== 4'h0) begin errors++; $display("FAIL rst_hresp got=%h exp=0", HRESP); end
    checks++; if (HRDATA !== '0) begin errors++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
    checks++; if (M_HSEL !== 1'b0 || M_HTRANS !== 2'b00) begin errors++; $display("FAIL rst_msel got=%b/%b exp=0/00", M_HSEL, M_HTRANS); end
    checks++; if (M_HREADY !== 1'b1 || M_HMASTLOCK !== 1'b0) begin errors++; $display("FAIL rst_mready_lock got=%b/%b exp=1/0", M_HREADY, M_HMASTLOCK); end
    checks++; if (M_HADDR !== 32'h0 || M_HWDATA !== 32'h0) begin errors++; $display("FAIL rst_maddr_wdata got=%h/%h exp=0/0", M_HADDR, M_HWDATA); end
    checks++; if (M_HSIZE !== 3'h0 || M_HPROT !== 4'h0 || M_HWRITE !== 1'b0) begin errors++; $display("FAIL rst_mctrl got=%h/%h/%b exp=0/0/0", M_HSIZE, M_HPROT, M_HWRITE); end
    HRESETn = 1'b1;
  endtask

  // All four requesters at once; from last=3 the order is 0,1,2,3.
  task automatic test_round_robin(input logic [31:0] base);
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) req(i, base + 32'(i * 4), 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) idle_req(i);
    checks++; if (HREADYOUT !== 4'h0) begin errors++; $display("FAIL rr_stall got=%h exp=0", HREADYOUT); end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = base + 32'(k * 4);
      checks++;
      if (M_HSEL !== 1'b1 || M_HADDR !== exp) begin
        errors++; $display("FAIL rr_order k=%0d got sel=%b addr=%h exp sel=1 addr=%h", k, M_HSEL, M_HADDR, exp);
      end
      tick(); tick();
    end
    checks++; if (HREADYOUT !== 4'hF) begin errors++; $display("FAIL rr_done got=%h exp=f", HREADYOUT); end
  endtask

  task automatic test_single_write();
    req(0, 32'h10, 1'b1, 1'b0);
    tick();
    idle_req(0); HWDATA[0] = 32'hA5;
    checks++; if (HREADYOUT[0] !== 1'b0) begin errors++; $display("FAIL wr_stall got=%b exp=0", HREADYOUT[0]); end
    tick();
    checks++; if (M_HSEL !== 1'b1 || M_HTRANS !== 2'b10) begin errors++; $display("FAIL wr_addr_phase got=%b/%b exp=1/10", M_HSEL, M_HTRANS); end
    checks++; if (M_HADDR !== 32'h10 || M_HWRITE !== 1'b1) begin errors++; $display("FAIL wr_addr got=%h/%b exp=10/1", M_HADDR, M_HWRITE); end
    checks++; if (M_HSIZE !== 3'b010 || M_HPROT !== 4'b0011) begin errors++; $display("FAIL wr_ctrl got=%h/%h exp=2/3", M_HSIZE, M_HPROT); end
    tick();
    checks++; if (M_HWDATA !== 32'hA5 || M_HSEL !== 1'b0 || M_HTRANS !== 2'b00) begin errors++; $display("FAIL wr_data got=%h/%b/%b exp=a5/0/00", M_HWDATA, M_HSEL, M_HTRANS); end
    checks++; if (HREADYOUT[0] !== 1'b0) begin errors++; $display("FAIL wr_wait got=%b exp=0", HREADYOUT[0]); end
    tick();
    checks++; if (HREADYOUT[0] !== 1'b1 || HRESP[0] !== 1'b0) begin errors++; $display("FAIL wr_done got=%b/%b exp=1/0", HREADYOUT[0], HRESP[0]); end
  endtask

  task automatic test_read_wait();
    req(1, 32'h20, 1'b0, 1'b0);
    tick();
    idle_req(1);
    tick();
    tick();
    M_HREADYOUT = 1'b0;
    tick();
    checks++; if (M_HREADY !== 1'b0) begin errors++; $display("FAIL rd_mready got=%b exp=0", M_HREADY); end
    tick();
    tick();
    M_HREADYOUT = 1'b1; M_HRDATA = 32'h5A;
    checks++; if (HREADYOUT[1] !== 1'b0) begin errors++; $display("FAIL rd_wait got=%b exp=0", HREADYOUT[1]); end
    tick();
    M_HRDATA = 32'h0;
    checks++; if (HREADYOUT[1] !== 1'b1 || HRDATA[1] !== 32'h5A) begin errors++; $display("FAIL rd_done got=%b/%h exp=1/5a", HREADYOUT[1], HRDATA[1]); end
  endtask

  task automatic test_error();
    req(2, 32'h30, 1'b1, 1'b0);
    tick();
    idle_req(2); HWDATA[2] = 32'h11;
    tick();
    tick();
    M_HREADYOUT = 1'b0; M_HRESP = 1'b1;
    tick();
    M_HREADYOUT = 1'b1;
    checks++; if (HREADYOUT[2] !== 1'b0 || HRESP[2] !== 1'b1) begin errors++; $display("FAIL err_first got=%b/%b exp=0/1", HREADYOUT[2], HRESP[2]); end
    tick();
    M_HRESP = 1'b0;
    checks++; if (HREADYOUT[2] !== 1'b1 || HRESP[2] !== 1'b1) begin errors++; $display("FAIL err_second got=%b/%b exp=1/1", HREADYOUT[2], HRESP[2]); end
    checks++;
    if ({HREADYOUT[3], HREADYOUT[1:0]} !== 3'b111 || {HRESP[3], HRESP[1:0]} !== 3'b000) begin
      errors++; $display("FAIL err_others got=%h/%h exp=b/0 (bit2 ignored)", HREADYOUT, HRESP);
    end
    tick();
    checks++; if (HREADYOUT[2] !== 1'b1 || HRESP[2] !== 1'b0 || M_HSEL !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b/%b/%b exp=1/0/0", HREADYOUT[2], HRESP[2], M_HSEL); end
  endtask

  task automatic test_reset_mid();
    req(3, 32'h60, 1'b1, 1'b0);
    tick();
    idle_req(3); HWDATA[3] = 32'h77;
    tick();
    tick();
    M_HREADYOUT = 1'b0;
    #1 HRESETn = 1'b0;
    #1;
    checks++; if (HREADYOUT !== 4'hF || HRESP !== 4'h0 || HRDATA !== '0) begin errors++; $display("FAIL rstm_req got=%h/%h exp=f/0", HREADYOUT, HRESP); end
    checks++; if (M_HSEL !== 1'b0 || M_HTRANS !== 2'b00 || M_HREADY !== 1'b1) begin errors++; $display("FAIL rstm_mctrl got=%b/%b/%b exp=0/00/1", M_HSEL, M_HTRANS, M_HREADY); end
    checks++; if (M_HADDR !== 32'h0 || M_HWDATA !== 32'h0 || M_HWRITE !== 1'b0) begin errors++; $display("FAIL rstm_mdata got=%h/%h exp=0/0", M_HADDR, M_HWDATA); end
    #2 HRESETn = 1'b1;
    M_HREADYOUT = 1'b1;
    req(0, 32'h70, 1'b0, 1'b0);
    tick();
    idle_req(0);
    tick();
    checks++; if (M_HSEL !== 1'b1 || M_HADDR !== 32'h70) begin errors++; $display("FAIL rstm_post_addr got=%b/%h exp=1/70", M_HSEL, M_HADDR); end
    tick();
    tick();
    checks++; if (HREADYOUT !== 4'hF) begin errors++; $display("FAIL rstm_post_done got=%h exp=f", HREADYOUT); end
    tick();
    checks++; if (M_HSEL !== 1'b0) begin errors++; $display("FAIL rstm_pend_cleared got=%b exp=0", M_HSEL); end
  endtask

  task automatic test_lock();
    logic [31:0] exp_addr;
    logic        exp_lock;
    int          n;
`ifdef PERIPHERAL_AHB3_ARB_LOCK_EN
    exp_addr = 32'h44; exp_lock = 1'b1;
`else
    exp_addr = 32'h50; exp_lock = 1'b0;
`endif
    req(1, 32'h40, 1'b0, 1'b1);
    tick();
    idle_req(1);
    req(0, 32'h50, 1'b0, 1'b0);
    tick();
    idle_req(0);
    checks++; if (M_HADDR !== 32'h40 || M_HMASTLOCK !== exp_lock) begin errors++; $display("FAIL lock_first got=%h/%b exp=40/%b", M_HADDR, M_HMASTLOCK, exp_lock); end
    tick();
    tick();
    req(1, 32'h44, 1'b0, 1'b0);
    tick();
    idle_req(1);
    n = 0;
    while (M_HSEL !== 1'b1 && n < 6) begin tick(); n++; end
    checks++; if (n >= 6 || M_HADDR !== exp_addr) begin errors++; $display("FAIL lock_next got=%h waited=%0d exp=%h", M_HADDR, n, exp_addr); end
    repeat (8) tick();
    checks++; if (HREADYOUT !== 4'hF) begin errors++; $display("FAIL lock_drain got=%h exp=f", HREADYOUT); end
  endtask

  initial begin
    HSEL = '0; HWRITE = '0; HMASTLOCK = '0; HREADY = '1;
    HADDR = '0; HWDATA = '0; HSIZE = '0; HPROT = '0; HTRANS = '0;
    M_HRDATA = '0; M_HREADYOUT = 1'b1; M_HRESP = 1'b0;
    test_reset();
    test_round_robin(32'h100);
    test_round_robin(32'h200);
    test_single_write();
    test_read_wait();
    test_error();
    test_reset_mid();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
